// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
// The optional match counter is enabled by defining SEQ_DETECT_CNT_EN.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        HIT  = 2'd2
    } state_t;

    localparam int DEFAULT_MAX_LEN = 8;

    // A pattern is usable only if it has at least two bits and fits the window.
    function automatic logic len_legal(input logic [31:0] len, input int max_len);
        return (len >= 32'd2) && (len <= 32'(max_len));
    endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter for seq_detect_prog (built only with SEQ_DETECT_CNT_EN).
module seq_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Counter register: clear wins over increment, and the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt <= {CNT_W{1'b0}};
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with Moore match flag and overlap control.
// Define SEQ_DETECT_CNT_EN to add the saturating match_cnt output.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i,
    input  logic                         i_valid,
    input  logic                         load,
    input  logic [MAX_LEN-1:0]           pat_in,
    input  logic [$clog2(MAX_LEN+1)-1:0] len_in,
    input  logic                         ovl_in,
    output logic                         y,
    output logic                         cfg_ok
`ifdef SEQ_DETECT_CNT_EN
    ,
    output logic [CNT_W-1:0]             match_cnt
`endif
);

    localparam int LW = $clog2(MAX_LEN+1);

    state_t             state_r, state_nx;
    logic [MAX_LEN-1:0] pat_r, pat_nx;
    logic [LW-1:0]      len_r, len_nx;
    logic               ovl_r, ovl_nx;
    logic [MAX_LEN-1:0] win_r, win_nx;
    logic [LW-1:0]      fill_r, fill_nx;
    logic               y_r;
    logic               cfg_ok_r;

    logic [MAX_LEN-1:0] win_shift_s;
    logic [LW-1:0]      fill_inc_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               hit_s;

    assign win_shift_s = (win_r << 1) | {{(MAX_LEN-1){1'b0}}, i};
    assign fill_inc_s  = (fill_r >= len_r) ? len_r : (fill_r + LW'(1));
    assign hit_s       = (fill_inc_s == len_r) &&
                         (((win_shift_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});

    // Compare mask: only the len least-significant window bits take part.
    always_comb begin
        mask_s = {MAX_LEN{1'b0}};
        for (int k = 0; k < MAX_LEN; k++) begin
            mask_s[k] = (32'(k) < 32'(len_r));
        end
    end

    // Next-state logic: load has priority and discards any bit sampled alongside it.
    always_comb begin
        state_nx = state_r;
        pat_nx   = pat_r;
        len_nx   = len_r;
        ovl_nx   = ovl_r;
        win_nx   = win_r;
        fill_nx  = fill_r;
        if (load) begin
            pat_nx   = pat_in;
            len_nx   = len_in;
            ovl_nx   = ovl_in;
            win_nx   = {MAX_LEN{1'b0}};
            fill_nx  = {LW{1'b0}};
            state_nx = len_legal(32'(len_in), MAX_LEN) ? HUNT : IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nx = IDLE;
                end
                HUNT, HIT: begin
                    if (i_valid) begin
                        win_nx   = win_shift_s;
                        fill_nx  = (hit_s && !ovl_r) ? {LW{1'b0}} : fill_inc_s;
                        state_nx = hit_s ? HIT : HUNT;
                    end else begin
                        state_nx = HUNT;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // State and output registers; outputs are taken from the next state so they stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            pat_r    <= {MAX_LEN{1'b0}};
            len_r    <= {LW{1'b0}};
            ovl_r    <= 1'b0;
            win_r    <= {MAX_LEN{1'b0}};
            fill_r   <= {LW{1'b0}};
            y_r      <= 1'b0;
            cfg_ok_r <= 1'b0;
        end else begin
            state_r  <= state_nx;
            pat_r    <= pat_nx;
            len_r    <= len_nx;
            ovl_r    <= ovl_nx;
            win_r    <= win_nx;
            fill_r   <= fill_nx;
            y_r      <= (state_nx == HIT);
            cfg_ok_r <= (state_nx != IDLE);
        end
    end

    assign y      = y_r;
    assign cfg_ok = cfg_ok_r;

`ifdef SEQ_DETECT_CNT_EN
    logic cnt_inc_s;

    assign cnt_inc_s = !load && i_valid && (state_r != IDLE) && hit_s;

    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc_s),
        .clr (load),
        .cnt (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed self-checking bench for seq_detect_prog (MAX_LEN=8, CNT_W=2).
// match_cnt checks are active when SEQ_DETECT_CNT_EN is defined.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LW      = $clog2(MAX_LEN+1);

    logic               clk;
    logic               rst;
    logic               i;
    logic               i_valid;
    logic               load;
    logic [MAX_LEN-1:0] pat_in;
    logic [LW-1:0]      len_in;
    logic               ovl_in;
    logic               y;
    logic               cfg_ok;
`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    int vectors;
    int errors;

    seq_detect_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i         (i),
        .i_valid   (i_valid),
        .load      (load),
        .pat_in    (pat_in),
        .len_in    (len_in),
        .ovl_in    (ovl_in),
        .y         (y),
        .cfg_ok    (cfg_ok)
`ifdef SEQ_DETECT_CNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int exp);
`ifdef SEQ_DETECT_CNT_EN
        check(tag, 32'(match_cnt), 32'(exp));
`endif
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic do_load(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l,
                           input logic o, input logic v, input logic b);
        load    = 1'b1;
        pat_in  = p;
        len_in  = l;
        ovl_in  = o;
        i_valid = v;
        i       = b;
        @(negedge clk);
        load    = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic step(input string tag, input logic v, input logic b, input logic exp_y);
        i_valid = v;
        i       = b;
        @(negedge clk);
        check(tag, 32'(y), 32'(exp_y));
    endtask

    task automatic stream(input string tag, input logic [15:0] bits,
                          input logic [15:0] exp_y, input int n);
        logic [15:0] b_v;
        logic [15:0] e_v;
        b_v = bits;
        e_v = exp_y;
        for (int k = n - 1; k >= 0; k--) begin
            step(tag, 1'b1, b_v[k], e_v[k]);
        end
        i_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b1;
        i       = 1'b0;
        i_valid = 1'b0;
        load    = 1'b0;
        pat_in  = {MAX_LEN{1'b0}};
        len_in  = {LW{1'b0}};
        ovl_in  = 1'b0;
        #7;
        check("rst_y", 32'(y), 32'd0);
        check("rst_cfg_ok", 32'(cfg_ok), 32'd0);
        check_cnt("rst_cnt", 0);
        @(negedge clk);
        rst = 1'b0;

        // Before any load the detector ignores the stream.
        stream("idle_y", 16'b11, 16'b00, 2);

        // Overlapping 1010.
        do_load(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0);
        check("ovl_cfg_ok", 32'(cfg_ok), 32'd1);
        stream("ovl_y", 16'b101010, 16'b000101, 6);
        check_cnt("ovl_cnt", 2);
        step("ovl_hit_exit", 1'b0, 1'b0, 1'b0);

        // Non-overlapping 1010.
        do_load(8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b0);
        check_cnt("load_clr_cnt", 0);
        stream("novl_y", 16'b10101010, 16'b00010001, 8);
        check_cnt("novl_cnt", 2);

        // Pattern 11 with overlap: back-to-back hits.
        do_load(8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0);
        stream("p11_y", 16'b111, 16'b011, 3);
        check_cnt("p11_cnt", 2);

        // Illegal lengths; the first load also lands while y is high.
        do_load(8'b0000_0011, 4'd0, 1'b1, 1'b0, 1'b0);
        check("len0_y_drop", 32'(y), 32'd0);
        check("len0_cfg_ok", 32'(cfg_ok), 32'd0);
        stream("len0_y", 16'b1111, 16'b0000, 4);
        do_load(8'b0000_0011, 4'd9, 1'b1, 1'b0, 1'b0);
        check("len9_cfg_ok", 32'(cfg_ok), 32'd0);
        stream("len9_y", 16'b1111, 16'b0000, 4);

        // Load mid-pattern together with the completing bit.
        do_load(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0);
        stream("pre_y", 16'b101, 16'b000, 3);
        do_load(8'b0000_1010, 4'd4, 1'b1, 1'b1, 1'b0);
        check("ld_valid_y", 32'(y), 32'd0);
        check("ld_valid_cfg_ok", 32'(cfg_ok), 32'd1);
        stream("refill_y", 16'b01010, 16'b00001, 5);

        // Asynchronous reset while y is high.
        do_load(8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0);
        stream("arst_pre_y", 16'b11, 16'b01, 2);
        #2 rst = 1'b1;
        #1;
        check("arst_y", 32'(y), 32'd0);
        check("arst_cfg_ok", 32'(cfg_ok), 32'd0);
        check_cnt("arst_cnt", 0);
        rst = 1'b0;
        @(negedge clk);

        // Five non-overlapping matches saturate a 2-bit counter.
        do_load(8'b0000_0011, 4'd2, 1'b0, 1'b0, 1'b0);
        stream("sat_y", 16'b1111111111, 16'b0101010101, 10);
        check_cnt("sat_cnt", 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
